ram_sp_param: RTL and testbench
===============================

Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM for the RISC datapath. It is the next generation of the fixed 256x16 data/instruction RAM.
- Width, depth and output pipelining are configurable.
- Adds a req/ready handshake, a dout_valid qualifier, and a hardware clear engine. The clear engine fills every location with CLEAR_VAL after reset or on request.
- Sits between the control unit / memory-access stage and the register file. All ports are synchronous to the 100 MHz system clk.

Parameters:
- DATA_W, 16, data word width in bits (1..64).
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_VAL, 0, word written to every location by the clear engine.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  1  access request; sampled only while ready=1
- we  input  1  1 = write, 0 = read; qualified by req
- addr  input  ADDR_W  word address
- din  input  DATA_W  write data
- clr  input  1  pulse: start full-memory clear
- ready  output  1  1 = RUN state, accesses accepted
- busy  output  1  1 = clear in progress (CLEAR state)
- dout  output  DATA_W  read / write-through data
- dout_valid  output  1  one-cycle strobe, dout valid this cycle

Behaviour:
- Reset (rst_n=0, async):
  - state=CLEAR, clr_ptr=0.
  - ready=0, busy=1, dout=0, dout_valid=0, all pipeline valid bits=0.
  - Array contents are not reset directly; the clear engine overwrites them after release.
- CLEAR state:
  - Each cycle write CLEAR_VAL to array[clr_ptr], then increment clr_ptr.
  - When clr_ptr = DEPTH-1 is written, go to RUN next cycle. A clear therefore takes exactly DEPTH cycles: ready rises DEPTH cycles after the first rising edge with rst_n=1.
  - req, we, addr, din are ignored (no write, no dout_valid).
  - clr is ignored.
- RUN state: ready=1, busy=0.
  - Accept: a request is accepted on an edge where req=1 and ready=1.
  - Write (we=1): array[addr]<=din. Write-first: stage-1 data = din, and the access produces dout_valid like a read.
  - Read (we=0): stage-1 data = array[addr].
  - OUT_REG=0: dout/dout_valid update on the accepting edge; visible the cycle after the request is presented.
  - OUT_REG=1: one further register stage, so visible one cycle later.
  - Back-to-back accesses every cycle at full throughput, no bubbles.
  - Read of an address written in the previous cycle returns the new data (array is written at the edge).
  - dout holds its last value when dout_valid=0.
- clr=1 in RUN:
  - Go to CLEAR next edge; ready drops after that edge.
  - If req=1 on the same edge as clr, that request is still accepted and completes (clr has lower priority on that edge).
  - Reads already in the pipeline complete normally: a stage-2 word with OUT_REG=1 still emits dout_valid during the first CLEAR cycle.
- Wrap: clr_ptr is ADDR_W+1 bits or compared at DEPTH-1. addr is used modulo DEPTH by construction.
- Reset mid-clear or mid-access: immediate return to reset values. Clear restarts from address 0; in-flight reads are discarded (no dout_valid).

Test Plan:
1. Defaults, release rst_n, hold req=0.
   - Required: busy=1 for exactly 256 cycles, then ready=1.
   - Required: reads of addr 0x00, 0x7F, 0xFF each return 0x0000 with dout_valid one cycle after req.
2. Write 0xBEEF to 0x12, then read 0x12 the next cycle.
   - Required: write cycle returns dout=0xBEEF valid; read returns 0xBEEF; back-to-back, no stall.
3. OUT_REG=1, reads of 0x01, 0x02, 0x03 in consecutive cycles after writing 0x1111/0x2222/0x3333.
   - Required: dout_valid on cycles +2, +3, +4 with those values in order.
4. Write 0xAAAA to 0x40, then pulse clr with a simultaneous read of 0x40.
   - Required: read returns 0xAAAA valid; ready low for 256 cycles; afterwards a read of 0x40 returns CLEAR_VAL.
5. req=1 with we=1, addr=0x05, din=0x5555 during CLEAR.
   - Required: no dout_valid; after clear completes, a read of 0x05 returns CLEAR_VAL.
6. Assert rst_n=0 at clear cycle 100, release after 3 cycles.
   - Required: dout=0 and dout_valid=0 immediately; busy stays high for exactly 256 further cycles after release.

Source files
------------

// File: rtl/ram_sp_param_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_param_if
// Brief    : Access bus between the datapath and the single-port RAM.
// Revision : 1.0
// ============================================================================
interface ram_sp_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              clr;
    logic              ready;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    modport master (
        output req, we, addr, din, clr,
        input  ready, busy, dout, dout_valid
    );

    modport slave (
        input  req, we, addr, din, clr,
        output ready, busy, dout, dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_param
// Brief    : Parametrised single-port synchronous RAM with handshake,
//            optional output register and a full-memory clear engine.
// Revision : 1.0
// ============================================================================
module ram_sp_param #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    ram_sp_param_if.slave bus
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_busy;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_valid;

    logic              w_accept;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_accept  = bus.req && r_ready;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;

    // The clear engine owns the single write port for the whole CLEAR state.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.addr;
        w_mem_wdata = bus.din;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_wdata = CLEAR_VAL;
        end else if (w_accept && bus.we) begin
            w_mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_clr_ptr  <= '0;
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= bus.we ? bus.din : r_mem[bus.addr];
            end
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A request on the same edge as clr was accepted above.
                    if (bus.clr) begin
                        r_state   <= ST_CLEAR;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_s2_data;
            logic              r_s2_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bus.dout       = r_s2_data;
            assign bus.dout_valid = r_s2_valid;
        end else begin : g_no_out_reg
            assign bus.dout       = r_s1_data;
            assign bus.dout_valid = r_s1_valid;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sp_param
// Brief    : Directed bench driving an OUT_REG=0 and an OUT_REG=1 RAM in lockstep.
// Revision : 1.0
// ============================================================================
module tb_ram_sp_param;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic          clr   = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] din   = '0;

    int checks = 0;
    int errors = 0;

    logic          op_we   [8];
    logic [AW-1:0] op_addr [8];
    logic [DW-1:0] op_din  [8];
    logic [DW-1:0] op_exp  [8];
    int            n_ops = 0;

    ram_sp_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    ram_sp_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.req  = req;
    assign if0.we   = we;
    assign if0.addr = addr;
    assign if0.din  = din;
    assign if0.clr  = clr;
    assign if1.req  = req;
    assign if1.we   = we;
    assign if1.addr = addr;
    assign if1.din  = din;
    assign if1.clr  = clr;

    ram_sp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    ram_sp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] e);
        op_we[n_ops]   = w;
        op_addr[n_ops] = a;
        op_din[n_ops]  = d;
        op_exp[n_ops]  = e;
        n_ops++;
    endtask

    // Issues the queued ops back to back; dut0 answers one cycle later, dut1 two.
    task automatic run_ops(input string tag);
        for (int i = 0; i <= n_ops + 1; i++) begin
            if (i < n_ops) begin
                req  = 1'b1;
                we   = op_we[i];
                addr = op_addr[i];
                din  = op_din[i];
            end else begin
                req = 1'b0;
                we  = 1'b0;
            end
            tick;
            check_val({tag, "_rdy"}, 64'(if0.ready & if1.ready), 1);
            if (i < n_ops) begin
                check_val({tag, "_v0"}, 64'(if0.dout_valid), 1);
                check_val({tag, "_d0"}, 64'(if0.dout), 64'(op_exp[i]));
            end else begin
                check_val({tag, "_v0_idle"}, 64'(if0.dout_valid), 0);
                check_val({tag, "_d0_hold"}, 64'(if0.dout), 64'(op_exp[n_ops-1]));
            end
            if (i >= 1 && i <= n_ops) begin
                check_val({tag, "_v1"}, 64'(if1.dout_valid), 1);
                check_val({tag, "_d1"}, 64'(if1.dout), 64'(op_exp[i-1]));
            end else begin
                check_val({tag, "_v1_idle"}, 64'(if1.dout_valid), 0);
                if (i > 0) check_val({tag, "_d1_hold"}, 64'(if1.dout), 64'(op_exp[n_ops-1]));
            end
        end
        n_ops = 0;
    endtask

    // Counts busy cycles; optionally presents a stray write mid-clear.
    task automatic wait_clear(input string tag, input int start, input bit stray);
        int   n    = start;
        logic leak = 1'b0;
        while (if0.busy && n < 400) begin
            if (stray && n == 20) begin
                req  = 1'b1;
                we   = 1'b1;
                addr = 8'h05;
                din  = 16'h5555;
            end
            if (n == 200) begin
                req = 1'b0;
                we  = 1'b0;
            end
            tick;
            n++;
            leak = leak | if0.dout_valid | if1.dout_valid;
        end
        req = 1'b0;
        we  = 1'b0;
        check_val({tag, "_busy_cycles"}, 64'(n), 256);
        check_val({tag, "_ready"}, 64'(if0.ready & if1.ready), 1);
        check_val({tag, "_busy"}, 64'(if0.busy | if1.busy), 0);
        check_val({tag, "_no_valid"}, 64'(leak), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_ready"}, 64'(if0.ready | if1.ready), 0);
        check_val({tag, "_busy"}, 64'(if0.busy & if1.busy), 1);
        check_val({tag, "_d0"}, 64'(if0.dout), 0);
        check_val({tag, "_d1"}, 64'(if1.dout), 0);
        check_val({tag, "_v0"}, 64'(if0.dout_valid), 0);
        check_val({tag, "_v1"}, 64'(if1.dout_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) tick;
        check_reset_state("rst");
        rst_n = 1'b1;
        wait_clear("t1", 0, 1'b0);

        add_op(1'b0, 8'h00, 16'h0000, 16'h0000);
        add_op(1'b0, 8'h7F, 16'h0000, 16'h0000);
        add_op(1'b0, 8'hFF, 16'h0000, 16'h0000);
        run_ops("t1_rd");

        add_op(1'b1, 8'h12, 16'hBEEF, 16'hBEEF);
        add_op(1'b0, 8'h12, 16'h0000, 16'hBEEF);
        run_ops("t2");

        add_op(1'b1, 8'h01, 16'h1111, 16'h1111);
        add_op(1'b1, 8'h02, 16'h2222, 16'h2222);
        add_op(1'b1, 8'h03, 16'h3333, 16'h3333);
        add_op(1'b0, 8'h01, 16'h0000, 16'h1111);
        add_op(1'b0, 8'h02, 16'h0000, 16'h2222);
        add_op(1'b0, 8'h03, 16'h0000, 16'h3333);
        run_ops("t3");

        add_op(1'b1, 8'h40, 16'hAAAA, 16'hAAAA);
        run_ops("t4_wr");
        req  = 1'b1;
        we   = 1'b0;
        addr = 8'h40;
        clr  = 1'b1;
        tick;
        req = 1'b0;
        clr = 1'b0;
        check_val("t4_clr_v0", 64'(if0.dout_valid), 1);
        check_val("t4_clr_d0", 64'(if0.dout), 'hAAAA);
        check_val("t4_clr_ready", 64'(if0.ready | if1.ready), 0);
        check_val("t4_clr_busy", 64'(if0.busy & if1.busy), 1);
        check_val("t4_clr_v1_early", 64'(if1.dout_valid), 0);
        tick;
        check_val("t4_clr_v1", 64'(if1.dout_valid), 1);
        check_val("t4_clr_d1", 64'(if1.dout), 'hAAAA);
        check_val("t4_clr_v0_end", 64'(if0.dout_valid), 0);
        wait_clear("t4", 1, 1'b1);

        add_op(1'b0, 8'h40, 16'h0000, 16'h0000);
        add_op(1'b0, 8'h05, 16'h0000, 16'h0000);
        run_ops("t5");

        add_op(1'b1, 8'h77, 16'h1234, 16'h1234);
        run_ops("t6_wr");
        req  = 1'b1;
        we   = 1'b0;
        addr = 8'h77;
        tick;
        req = 1'b0;
        check_val("t6_pre_v0", 64'(if0.dout_valid), 1);
        check_val("t6_pre_d0", 64'(if0.dout), 'h1234);
        rst_n = 1'b0;
        #1;
        check_reset_state("t6_rst_access");
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (100) tick;
        check_val("t6_mid_busy", 64'(if0.busy & if1.busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_state("t6_rst_clear");
        repeat (3) tick;
        rst_n = 1'b1;
        wait_clear("t6", 0, 1'b0);

        add_op(1'b0, 8'h77, 16'h0000, 16'h0000);
        run_ops("t6_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
